// File: rtl/sc_pkg.sv
// Shared constants and types for the scoring-path metadata arbiter.
package sc_pkg;
  localparam int N_LANES = 37;
  localparam int META_W  = 16;
  localparam int LANE_W  = 6;

  typedef logic [LANE_W-1:0] lane_idx_t;
endpackage

// File: rtl/sc_rr_picker.sv
// Round-robin picker: the first set request at or after last+1 (mod N) wins.
module sc_rr_picker
  import sc_pkg::*;
#(
  parameter int N = N_LANES
) (
  input  logic [N-1:0] req,
  input  lane_idx_t    last,
  output logic         gnt_vld,
  output lane_idx_t    gnt_idx
);

  int        idx;
  lane_idx_t cand;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx  = (int'(last) + 1 + k) % N;
      cand = lane_idx_t'(idx);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sc_metadata_arbiter.sv
// Shares the single-port note-metadata RAM among the note-matcher lanes,
// one round-robin read per cycle, loading each lane's link register.
module sc_metadata_arbiter
  import sc_pkg::*;
#(
  parameter int N_REQ  = N_LANES,
  parameter int DW     = META_W,
  parameter int PW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pause,
  input  logic                   restart,
  input  logic [N_REQ-1:0]       metadata_request,
  output logic [N_REQ-1:0]       metadata_available,
  output logic [N_REQ*DW-1:0]    metadata_link,
  output logic                   ram_en,
  output logic [LANE_W+PW-1:0]   ram_addr,
  input  logic [DW-1:0]          ram_dout
);

  logic [PW-1:0]    ptr [N_REQ];
  logic [DW-1:0]    link [N_REQ];
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] inflight;
  logic [N_REQ-1:0] avail;
  lane_idx_t        last_grant;

  logic [RD_LAT:0]  vld_p;
  lane_idx_t        lane_p [RD_LAT+1];

  logic             gnt_vld;
  lane_idx_t        gnt_idx;
  logic             grant;
  logic             ret;
  lane_idx_t        ret_lane;

  sc_rr_picker #(.N(N_REQ)) u_picker (
    .req     (pending),
    .last    (last_grant),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant    = gnt_vld && !pause && !restart;
  assign ret      = vld_p[RD_LAT];
  assign ret_lane = lane_p[RD_LAT];

  // Stage p0 is the issue cycle (ram_en); stage pRD_LAT lines up with ram_dout.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pending  <= '1;
      inflight <= '0;
      avail    <= '0;
      vld_p    <= '0;
      ram_en   <= 1'b0;
      for (int i = 0; i < N_REQ; i++) ptr[i] <= '0;
      if (reset) begin
        ram_addr   <= '0;
        last_grant <= lane_idx_t'(N_REQ - 1);
      end
    end else begin
      ram_en <= grant;
      vld_p  <= {vld_p[RD_LAT-1:0], grant};
      for (int i = 0; i < N_REQ; i++) begin
        if (metadata_request[i] && !pending[i] && !inflight[i]) begin
          pending[i] <= 1'b1;
          avail[i]   <= 1'b0;
        end
      end
      if (grant) begin
        ram_addr          <= {gnt_idx, ptr[gnt_idx]};
        pending[gnt_idx]  <= 1'b0;
        inflight[gnt_idx] <= 1'b1;
        last_grant        <= gnt_idx;
      end
      if (ret) begin
        avail[ret_lane]    <= 1'b1;
        inflight[ret_lane] <= 1'b0;
        if (ptr[ret_lane] != '1) ptr[ret_lane] <= ptr[ret_lane] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    lane_p[0] <= gnt_idx;
    for (int k = 1; k <= RD_LAT; k++) lane_p[k] <= lane_p[k-1];
  end

  // Return stage: data arriving on a restart edge belongs to a discarded read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) link[i] <= '0;
    end else if (ret && !restart) begin
      link[ret_lane] <= ram_dout;
    end
  end

  assign metadata_available = avail;

  always_comb begin
    metadata_link = '0;
    for (int i = 0; i < N_REQ; i++) metadata_link[i*DW +: DW] = link[i];
  end

endmodule
